// File: rtl/fetch_seq_if.sv
// Program-ROM read and decode handshake bundle for fetch_seq.
// master = fetch sequencer side, slave = ROM/decode/execute side.
interface fetch_seq_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               ir_ready;
    logic               jump_en;
    logic [PC_W-1:0]    jump_addr;
    logic               halted;

    modport master (
        output pc, ir, ir_valid, halted,
        input  instr, ir_ready, jump_en, jump_addr
    );

    modport slave (
        input  pc, ir, ir_valid, halted,
        output instr, ir_ready, jump_en, jump_addr
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: drives ROM pc, captures instr into ir, halts on HALT_OP.
// Optional FETCH_PERF_EN macro adds fetch_count / stall_count performance counters.
module fetch_seq #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    fetch_seq_if.master bus,
    output logic       fsm_state
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [PC_W-1:0]    pc_q, pc_n;
    logic [INSTR_W-1:0] ir_q, ir_n;
    logic               valid_q, valid_n;
    logic               load;
    logic               capture;
    logic               stall;

    // Handshake: ir is transferred on an edge where ir_valid=1 and ir_ready=1,
    // except that a coincident jump_en flushes ir and the accept is void.
    assign load    = !valid_q || bus.ir_ready;
    assign capture = (state_q == FETCH) && !bus.jump_en && load;
    assign stall   = (state_q == FETCH) && !bus.jump_en && valid_q && !bus.ir_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            ir_q    <= ir_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        ir_n    = ir_q;
        valid_n = valid_q;
        case (state_q)
            FETCH: begin
                if (bus.jump_en) begin
                    pc_n    = bus.jump_addr;
                    valid_n = 1'b0;
                end else if (load) begin
                    ir_n    = bus.instr;
                    valid_n = 1'b1;
                    pc_n    = pc_q + PC_W'(1);
                    if (bus.instr[INSTR_W-1 -: 4] == HALT_OP) state_n = HALT;
                end
            end
            HALT: begin
                // pc stays frozen; only the pending HALT word can still drain
                if (bus.jump_en) begin
                    pc_n    = bus.jump_addr;
                    valid_n = 1'b0;
                    state_n = FETCH;
                end else if (valid_q && bus.ir_ready) begin
                    valid_n = 1'b0;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = valid_q;
    assign bus.halted   = (state_q == HALT);
    assign fsm_state    = state_q;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'h0000;
            stall_count <= 16'h0000;
        end else begin
            if (capture) fetch_count <= fetch_count + 16'h0001;
            if (stall)   stall_count <= stall_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed testbench for fetch_seq with a spec-level reference model and per-cycle compare.
module tb_fetch_seq;
    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    logic clk;
    logic rst;
    logic fsm_state;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    fetch_seq_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_seq #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00), .HALT_OP(4'hF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .fsm_state(fsm_state)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count),
        .stall_count(stall_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ROM ----------------
    logic [INSTR_W-1:0] rom [256];
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
        rom[8] = 16'hF000;
    end
    assign bus.instr = rom[bus.pc];

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [INSTR_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [PC_W-1:0]    m_pc;
    logic [INSTR_W-1:0] m_ir;
    logic               m_valid;
    logic               m_halted;
    logic               m_ok = 1'b0;
    logic [15:0]        m_fc;
    logic [15:0]        m_sc;

    always @(posedge clk) begin
        if (rst) begin
            m_ok     <= 1'b1;
            m_pc     <= 8'h00;
            m_ir     <= '0;
            m_valid  <= 1'b0;
            m_halted <= 1'b0;
            m_fc     <= 16'h0;
            m_sc     <= 16'h0;
        end else if (m_ok) begin
            if (bus.jump_en) begin
                m_pc     <= bus.jump_addr;
                m_valid  <= 1'b0;
                m_halted <= 1'b0;
            end else if (m_halted) begin
                if (bus.ir_ready) m_valid <= 1'b0;
            end else if (!m_valid || bus.ir_ready) begin
                m_ir     <= rom[m_pc];
                m_valid  <= 1'b1;
                m_pc     <= m_pc + 8'h01;
                m_halted <= (rom[m_pc][15:12] == 4'hF);
                m_fc     <= m_fc + 16'h1;
                exp_q.push_back(rom[m_pc]);
            end else begin
                m_sc <= m_sc + 16'h1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_ok) begin
            check("pc", 32'(bus.pc), 32'(m_pc));
            check("ir_valid", 32'(bus.ir_valid), 32'(m_valid));
            check("halted", 32'(bus.halted), 32'(m_halted));
            check("fsm_state", 32'(fsm_state), 32'(m_halted));
            if (m_valid) check("ir", 32'(bus.ir), 32'(m_ir));
`ifdef FETCH_PERF_EN
            check("fetch_count", 32'(fetch_count), 32'(m_fc));
            check("stall_count", 32'(stall_count), 32'(m_sc));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input string name, input logic [PC_W-1:0] pc,
                       input logic [INSTR_W-1:0] ir, input logic valid, input logic halted);
        check({name, ".pc"}, 32'(bus.pc), 32'(pc));
        check({name, ".ir"}, 32'(bus.ir), 32'(ir));
        check({name, ".ir_valid"}, 32'(bus.ir_valid), 32'(valid));
        check({name, ".halted"}, 32'(bus.halted), 32'(halted));
    endtask

    task automatic pulse_jump(input logic [PC_W-1:0] addr);
        bus.jump_en   = 1'b1;
        bus.jump_addr = addr;
        tick();
        bus.jump_en   = 1'b0;
        bus.jump_addr = 8'h00;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        bus.ir_ready  = 1'b1;
        bus.jump_en   = 1'b0;
        bus.jump_addr = 8'h00;
        tick(2);
        lit("reset", 8'h00, 16'h0000, 1'b0, 1'b0);

        // straight-line fetch
        rst = 1'b0;
        tick();
        lit("fetch0", 8'h01, 16'h1000, 1'b1, 1'b0);
        tick();
        lit("fetch1", 8'h02, 16'h1001, 1'b1, 1'b0);
        tick();
        lit("fetch2", 8'h03, 16'h1002, 1'b1, 1'b0);

        // back-pressure for 3 cycles
        bus.ir_ready = 1'b0;
        tick(3);
        lit("stall", 8'h03, 16'h1002, 1'b1, 1'b0);
`ifdef FETCH_PERF_EN
        check("stall_lit", 32'(stall_count), 32'd3);
        check("fetch_lit", 32'(fetch_count), 32'd3);
`endif

        // jump while ir_valid=1
        pulse_jump(8'h02);
        lit("jump", 8'h02, 16'h1002, 1'b0, 1'b0);
        bus.ir_ready = 1'b1;
        tick();
        lit("replay02", 8'h03, 16'h1002, 1'b1, 1'b0);
        tick();
        lit("replay03", 8'h04, 16'h1003, 1'b1, 1'b0);

        // run to HALT at address 08
        tick(5);
        lit("halt_cap", 8'h09, 16'hF000, 1'b1, 1'b1);
        bus.ir_ready = 1'b0;
        tick(2);
        lit("halt_hold", 8'h09, 16'hF000, 1'b1, 1'b1);
        bus.ir_ready = 1'b1;
        tick();
        lit("halt_acc", 8'h09, 16'hF000, 1'b0, 1'b1);
        tick(2);
        check("halt_frozen.pc", 32'(bus.pc), 32'h09);
        pulse_jump(8'h00);
        lit("resume", 8'h00, 16'hF000, 1'b0, 1'b0);
        tick();
        lit("resume_cap", 8'h01, 16'h1000, 1'b1, 1'b0);

        // wrap at 8'hFF
        pulse_jump(8'hFF);
        tick();
        lit("wrap", 8'h00, 16'h10FF, 1'b1, 1'b0);
        tick();
        lit("wrap_next", 8'h01, 16'h1000, 1'b1, 1'b0);

        // jump coincident with HALT on ROM, and jump to current pc
        pulse_jump(8'h08);
        pulse_jump(8'h08);
        lit("jump_vs_halt", 8'h08, 16'h1000, 1'b0, 1'b0);
        tick();
        lit("halt_again", 8'h09, 16'hF000, 1'b1, 1'b1);
        bus.ir_ready = 1'b0;
        tick();

        // mid-run reset in HALT with ir_valid=1, jump also requested
        rst = 1'b1;
        bus.jump_en   = 1'b1;
        bus.jump_addr = 8'h55;
        tick();
        lit("midreset", 8'h00, 16'h0000, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
        check("midreset.fetch_count", 32'(fetch_count), 32'd0);
        check("midreset.stall_count", 32'(stall_count), 32'd0);
`endif
        rst = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_addr = 8'h00;
        bus.ir_ready  = 1'b1;
        tick(3);
        lit("after_reset", 8'h03, 16'h1002, 1'b1, 1'b0);

        // random ready pattern with occasional jumps
        for (int i = 0; i < 60; i++) begin
            bus.ir_ready  = 1'($urandom_range(0, 1));
            bus.jump_en   = ($urandom_range(0, 7) == 0);
            bus.jump_addr = 8'($urandom_range(0, 12));
            tick();
        end
        bus.jump_en = 1'b0;
        tick(2);

        check("captures_seen", 32'(exp_q.size() > 20), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction fetch sequencer for the washing register machine; the initiator side of the program-ROM read interface.
- Drives the combinational ROM address `pc` and captures the returned `instr` into an instruction register (IR).
- Presents the IR to the decode/execute stage with a valid/ready handshake.
- Handles jump redirects from execute, and stops fetching on a HALT opcode.

Parameters:
- PC_W, 8: ROM address width.
- INSTR_W, 16: instruction width.
- RESET_PC, 8'h00: pc value after reset.
- HALT_OP, 4'hF: opcode in instr[INSTR_W-1:INSTR_W-4] that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  output  PC_W  ROM address; ROM returns instr combinationally in the same cycle.
- instr  input  INSTR_W  ROM data for the current pc.
- ir  output  INSTR_W  captured instruction presented to decode.
- ir_valid  output  1  ir holds an instruction not yet accepted.
- ir_ready  input  1  decode accepts ir this cycle when ir_valid=1.
- jump_en  input  1  redirect request from execute, one-cycle pulse.
- jump_addr  input  PC_W  redirect target.
- halted  output  1  fetch stopped by HALT_OP.

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, ir=0, ir_valid=0, halted=0, state=FETCH.
  - rst overrides every other input.
  - Reset mid-operation discards the IR contents and any pending jump.
- States: FETCH and HALT. halted=1 exactly when state=HALT.
- Load condition: load = (ir_valid==0) || ir_ready.
- FETCH, priority order per edge:
  1. jump_en=1: pc<=jump_addr, ir_valid<=0, ir unchanged. The IR is flushed even if ir_ready=1 this cycle; decode must ignore an accept coincident with a jump.
  2. else if load: ir<=instr, ir_valid<=1, pc<=pc+1 (modulo 2^PC_W, so 8'hFF -> 8'h00). If the upper opcode of instr == HALT_OP, state<=HALT.
  3. else: hold pc, ir and ir_valid (back-pressure).
- Latency and throughput:
  - An instruction at address A appears on ir one edge after pc==A with load=1.
  - Sustained rate is one instruction per cycle while ir_ready=1.
- HALT:
  - pc frozen at the address after the HALT instruction; no new captures.
  - The HALT instruction stays on ir with ir_valid=1 until accepted, then ir_valid<=0.
  - jump_en=1: pc<=jump_addr, ir_valid<=0, state<=FETCH, halted<=0 on the same edge.
  - Only rst or jump_en leaves HALT.
- Simultaneous events:
  - jump_en together with a HALT instr on the ROM in FETCH: the jump wins, the HALT is not captured, state stays FETCH.
  - Jump to the current pc: legal; it flushes the IR and refetches that address.
- Outputs are registered; pc is never combinationally dependent on instr, so there is no ROM loop.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output `fetch_count`, 16 bits.
  - Increments on every capture (FETCH, no jump, load=1), wrapping at 16'hFFFF -> 16'h0000.
  - Cleared by rst; not cleared by jump.
  - Adds output `stall_count`, 16 bits, with the same reset and wrap rules. It increments on each FETCH cycle with ir_valid=1, ir_ready=0 and jump_en=0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Straight-line fetch. ROM model has 16'h1000+addr at addresses 0..7; ir_ready=1; release rst. Required: pc 00,01,02..., ir 16'h1000 then 16'h1001 one cycle behind pc, ir_valid stays 1 from the second edge.
- Back-pressure. Hold ir_ready=0 for 3 cycles with ir=16'h1002. Required: pc stays 03, ir stays 16'h1002, ir_valid=1; with FETCH_PERF_EN, stall_count advances by 3.
- Jump. Pulse jump_en with jump_addr=8'h02 while ir_valid=1. Required: next edge pc=02 and ir_valid=0; following edge ir=16'h1002 and pc=03 (replays the 02,03,04 sequence).
- Halt. Place 16'hF000 at address 08. Required: after capture, halted=1, pc=09 frozen; ir=16'hF000 stays valid until ir_ready, then ir_valid=0. A jump_en to 8'h00 resumes with halted=0.
- Wrap. Jump to 8'hFF. Required: after the capture pc=8'h00; fetch continues from address 00.
- Mid-run reset. Assert rst while in HALT with ir_valid=1. Required: next edge pc=RESET_PC, ir=0, ir_valid=0, halted=0; with FETCH_PERF_EN, both counters are 0.
